// File: rtl/calc_engine_pkg.sv
// Shared types and op_sel encodings for the calculator arithmetic core.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HAVE1,
    CALC,
    SHOW_RES,
    ERR
  } calc_state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/calc_engine_if.sv
// Operand/result bundle between the keypad converters and calc_engine.
interface calc_engine_if #(
  parameter int W = 8
);
  logic           op1_valid;
  logic [W-1:0]   op1;
  logic           op2_valid;
  logic [W-1:0]   op2;
  logic [1:0]     op_sel;
  logic           in_error;
  logic           clear;
  logic [2*W-1:0] result;
  logic           done;
  logic           busy;
  logic [2*W-1:0] disp_value;
  logic           disp_valid;
  logic           error;

  modport master (
    output op1_valid, op1, op2_valid, op2, op_sel, in_error, clear,
    input  result, done, busy, disp_value, disp_valid, error
  );

  modport slave (
    input  op1_valid, op1, op2_valid, op2, op_sel, in_error, clear,
    output result, done, busy, disp_value, disp_valid, error
  );
endinterface

// File: rtl/calc_engine_booth_seq_mult.sv
// Radix-2 Booth multiplier, one iteration per cycle, W iterations per product.
module booth_seq_mult #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             done
);
  localparam int CW = $clog2(W);

  logic [W:0]     mcand;
  logic [W:0]     acc;
  logic [W-1:0]   mplr;
  logic           q_m1;
  logic           b_msb;
  logic           running;
  logic [CW-1:0]  count;

  logic [W:0]     m_sel;
  logic [W:0]     acc_in;
  logic [W-1:0]   q_in;
  logic           qm1_in;
  logic           b_msb_sel;
  logic [W+1:0]   sum;
  logic [W:0]     acc_nx;
  logic [W-1:0]   q_nx;
  logic [W-1:0]   hi_fix;

  // One Booth step; on start the first step runs directly on the incoming operands.
  // The sum is one bit wider than the accumulator so an unsigned multiplicand cannot
  // overflow before the shift. Unsigned mode folds the extra top multiplier digit
  // (zero-extended bit W) into the high half on the final step.
  always_comb begin
    m_sel     = mcand;
    acc_in    = acc;
    q_in      = mplr;
    qm1_in    = q_m1;
    b_msb_sel = b_msb;
    if (start) begin
      m_sel     = {(SIGNED ? a[W-1] : 1'b0), a};
      acc_in    = '0;
      q_in      = b;
      qm1_in    = 1'b0;
      b_msb_sel = b[W-1];
    end
    case ({q_in[0], qm1_in})
      2'b01:   sum = {acc_in[W], acc_in} + {m_sel[W], m_sel};
      2'b10:   sum = {acc_in[W], acc_in} - {m_sel[W], m_sel};
      default: sum = {acc_in[W], acc_in};
    endcase
    acc_nx = sum[W+1:1];
    q_nx   = {sum[0], q_in[W-1:1]};
    hi_fix = (!SIGNED && b_msb_sel) ? m_sel[W-1:0] : '0;
  end

  // Iteration sequencing, final product capture and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      q_m1    <= 1'b0;
      b_msb   <= 1'b0;
      running <= 1'b0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        running <= 1'b0;
      end else if (start || running) begin
        mcand <= m_sel;
        acc   <= acc_nx;
        mplr  <= q_nx;
        q_m1  <= q_in[0];
        b_msb <= b_msb_sel;
        if (start) begin
          count   <= CW'(1);
          running <= 1'b1;
        end else if (count == CW'(W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          product <= {acc_nx[W-1:0] + hi_fix, q_nx};
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/calc_engine.sv
// Calculator arithmetic core: operand capture, mul/add/sub and display selection.
module calc_engine
  import calc_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic          clk,
  input logic          rst,
  calc_engine_if.slave bus
);
  calc_state_t    state;
  logic [W-1:0]   op1_r;
  logic [W-1:0]   op2_r;
  logic [1:0]     opsel_r;

  logic           mult_start;
  logic           mult_abort;
  logic           mult_done;
  logic [2*W-1:0] mult_product;
  logic [2*W-1:0] addsub_res;
  logic [2*W-1:0] calc_value;
  logic           calc_ready;

  function automatic logic [2*W-1:0] ext2w(input logic [W-1:0] x);
    return SIGNED ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
  endfunction

  // The multiplier starts in the same cycle op2 is accepted so that W steps end
  // exactly on the last CALC cycle.
  assign mult_abort = bus.clear | bus.in_error;
  assign mult_start = (state == HAVE1) && bus.op2_valid && !bus.op1_valid &&
                      (bus.op_sel == OP_MUL) && !mult_abort;

  booth_seq_mult #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .abort   (mult_abort),
    .a       (op1_r),
    .b       (bus.op2),
    .product (mult_product),
    .done    (mult_done)
  );

  // Exact add/sub on operands widened to 2W, and selection of the finished value.
  always_comb begin
    addsub_res = '0;
    case (opsel_r)
      OP_ADD:  addsub_res = ext2w(op1_r) + ext2w(op2_r);
      OP_SUB:  addsub_res = ext2w(op1_r) - ext2w(op2_r);
      default: addsub_res = '0;
    endcase
    calc_value = addsub_res;
    calc_ready = 1'b1;
    if (opsel_r == OP_MUL) begin
      calc_value = mult_product;
      calc_ready = mult_done;
    end
  end

  // Control FSM with registered outputs; event priority clear > in_error > op1 > op2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      op1_r          <= '0;
      op2_r          <= '0;
      opsel_r        <= OP_MUL;
      bus.result     <= '0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.disp_value <= '0;
      bus.disp_valid <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.clear) begin
        state          <= IDLE;
        bus.error      <= 1'b0;
        bus.busy       <= 1'b0;
        bus.disp_valid <= 1'b0;
        bus.disp_value <= '0;
      end else if (bus.in_error) begin
        state          <= ERR;
        bus.error      <= 1'b1;
        bus.busy       <= 1'b0;
        bus.disp_valid <= 1'b0;
        bus.disp_value <= '0;
      end else begin
        case (state)
          IDLE, SHOW_RES: begin
            if (bus.op1_valid) begin
              op1_r          <= bus.op1;
              bus.disp_value <= ext2w(bus.op1);
              bus.disp_valid <= 1'b1;
              state          <= HAVE1;
            end
          end
          HAVE1: begin
            if (bus.op1_valid) begin
              op1_r          <= bus.op1;
              bus.disp_value <= ext2w(bus.op1);
            end else if (bus.op2_valid) begin
              if (bus.op_sel == OP_RSV) begin
                state          <= ERR;
                bus.error      <= 1'b1;
                bus.disp_valid <= 1'b0;
                bus.disp_value <= '0;
              end else begin
                op2_r          <= bus.op2;
                opsel_r        <= bus.op_sel;
                bus.disp_value <= ext2w(bus.op2);
                bus.busy       <= 1'b1;
                state          <= CALC;
              end
            end
          end
          CALC: begin
            if (calc_ready) begin
              bus.result     <= calc_value;
              bus.disp_value <= calc_value;
              bus.done       <= 1'b1;
              bus.busy       <= 1'b0;
              state          <= SHOW_RES;
            end
          end
          ERR:     state <= ERR;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
Parametrised sequential arithmetic core for the keypad calculator: captures two W-bit binary operands, runs multiply, add or subtract, and selects the value to display.
Replaces the fixed 8-bit Booth multiplier plus display-priority pair with one block that is generic in width, signedness and operation.
Sits between the BCD-to-binary converter and the binary-to-BCD converter.

Parameters:
W, 8, operand width in bits (2..16); results are 2W bits.
SIGNED, 1, 1 = operands and results are two's complement; 0 = unsigned.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
op1_valid  input  1  single-cycle pulse; op1 is valid
op1  input  W  first operand (binary)
op2_valid  input  1  single-cycle pulse; op2 is valid; starts the operation
op2  input  W  second operand (binary)
op_sel  input  2  00 = mul, 01 = add, 10 = sub (op1 - op2), 11 = reserved; sampled with op2_valid
in_error  input  1  upstream conversion error, level
clear  input  1  single-cycle pulse; abort and return to IDLE
result  output  2W  last computed result, held
done  output  1  single-cycle pulse; result is updated
busy  output  1  high while in CALC
disp_value  output  2W  value for the display path
disp_valid  output  1  disp_value is meaningful
error  output  1  sticky error flag

Behaviour:
- Reset: state IDLE; all outputs 0; internal operand and accumulator registers 0.
- Priority of events each cycle: rst > clear > in_error > op1_valid > op2_valid.
- States: IDLE, HAVE1, CALC, SHOW_RES, ERR.
- IDLE:
  - op1_valid: latch op1, go to HAVE1.
  - op2_valid alone: ignored.
  - op1_valid and op2_valid together: latch op1 only.
- HAVE1:
  - disp_value = op1 extended to 2W (sign-extended if SIGNED, else zero-extended); disp_valid = 1.
  - op1_valid again: overwrite op1, stay in HAVE1.
  - op2_valid with op_sel != 11: latch op2 and op_sel, go to CALC. disp_value shows op2 extended from the next cycle onward.
  - op2_valid with op_sel = 11: go to ERR.
- CALC:
  - busy = 1; op1_valid and op2_valid are ignored.
  - mul: radix-2 Booth, one iteration per cycle, W cycles. Accumulator is W+1 bits wide, so the most negative value times itself is exact.
  - add/sub: 1 cycle. Operands are extended to 2W before the operation; the result is exact, so there is no overflow.
  - Latency: if op2_valid is high in cycle t, CALC occupies t+1..t+W (mul) or t+1 (add/sub). result is updated and done = 1 in cycle t+W+1 (mul) or t+2 (add/sub). The state is SHOW_RES in that same cycle.
- SHOW_RES:
  - disp_value = result; disp_valid = 1; result is held.
  - op1_valid: latch the new op1, go to HAVE1. result is unchanged; disp_value switches to op1.
- ERR:
  - error = 1; disp_valid = 0; disp_value = 0; busy = 0.
  - Left only by clear or rst.
  - Entered from any state on in_error, including mid-CALC. The partial product is discarded, result is unchanged, and done is not asserted.
- clear, from any state: go to IDLE next cycle; error, disp_valid, busy and done go to 0; result is retained.
- rst in mid-CALC: everything returns to the reset values above, including result.
- Unsigned mode (SIGNED = 0): operands are zero-extended, and Booth uses a W+1-bit zero-extended multiplier.

Decomposition:
- Package calc_pkg holds:
  - state enum calc_state_t {IDLE, HAVE1, CALC, SHOW_RES, ERR}
  - op_sel constants OP_MUL = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_RSV = 2'b11
- Sub-module booth_seq_mult, parametrised W and SIGNED:
  - inputs: start, a, b
  - outputs: product (2W), done (pulse W cycles after start)
  - abort input driven by clear / in_error
- Add/sub, the FSM and display selection stay in calc_engine.

Test Plan:
- W=8, SIGNED=1; op1=12, op2=11, op_sel=00 -> disp shows 12 then 11; done exactly 9 cycles after op2_valid; result=132; disp_value=132.
- W=8, SIGNED=1; op1=-128, op2=-128, mul -> result=16384; op1=-7, op2=5, mul -> result=-35 (0xFFDD).
- W=8, SIGNED=1; op1=3, op2=10, op_sel=10 -> done 2 cycles after op2_valid; result=-7 (0xFFF9). add 127+127 -> 254.
- W=12, SIGNED=0; op1=4095, op2=4095, mul -> result=16769025; done 13 cycles after op2_valid.
- Protocol: op2_valid in IDLE ignored; op1_valid during CALC ignored; op_sel=11 -> error=1, disp_valid=0; clear -> IDLE with error=0.
- Abort: in_error 3 cycles into a mul -> ERR, no done, result unchanged. Separately, rst mid-CALC -> all outputs 0 the next cycle.
